// File: rtl/countdown_sprite_draw.sv
// Countdown digit compositor: boxes a 24x32 sprite on screen and shows it for a fixed
// number of frames after start, pulsing done when the window closes.
module countdown_sprite_draw #(
   parameter int unsigned X0          = 304,
   parameter int unsigned Y0          = 228,
   parameter logic [9:0]  KEY         = 10'd391,
   parameter int unsigned HOLD_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       start,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic [9:0] sprite [0:23][0:31],
   output logic [9:0] pix_rgb,
   output logic       pix_valid,
   output logic       active,
   output logic       done
);

   localparam logic [9:0] XLo     = 10'(X0);
   localparam logic [9:0] XHi     = 10'(X0 + 32);
   localparam logic [9:0] YLo     = 10'(Y0);
   localparam logic [9:0] YHi     = 10'(Y0 + 24);
   localparam logic [7:0] LastCnt = 8'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {StIdle, StShow, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       fc_q, fc_qq;
   logic       frame_tick;

   // Pixel pipeline
   logic       in_box_d, in_box_q, active_q;
   logic [4:0] col_d, col_q, row_d, row_q, row_idx;
   logic [9:0] c;
   logic       valid_d;
   logic [9:0] rgb_d;

   assign frame_tick = fc_q & ~fc_qq;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fc_q        <= 1'b0;
         fc_qq       <= 1'b0;
         state_q     <= StIdle;
         frame_cnt_q <= '0;
      end else begin
         fc_q        <= frame_clk;
         fc_qq       <= fc_q;
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // A restart in SHOW takes priority over the final frame tick.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StShow;
               frame_cnt_d = '0;
            end
         end
         StShow: begin
            if (start) begin
               frame_cnt_d = '0;
            end else if (frame_tick) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               if (frame_cnt_q == LastCnt) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign active = (state_q == StShow);
   assign done   = (state_q == StDone);

   // Low bits of the offset only; meaningful solely when in_box is set.
   assign in_box_d = (DrawX >= XLo) & (DrawX < XHi) & (DrawY >= YLo) & (DrawY < YHi);
   assign col_d    = DrawX[4:0] - XLo[4:0];
   assign row_d    = DrawY[4:0] - YLo[4:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         in_box_q <= 1'b0;
         active_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         in_box_q <= in_box_d;
         active_q <= active;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

   // Rows 24..31 only occur outside the box; clamp so the lookup stays in range.
   assign row_idx = (row_q < 5'd24) ? row_q : 5'd0;
   assign c       = sprite[row_idx][col_q];
   assign valid_d = in_box_q & active_q & (c != KEY);
   assign rgb_d   = valid_d ? c : 10'd0;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pix_valid <= 1'b0;
         pix_rgb   <= '0;
      end else begin
         pix_valid <= valid_d;
         pix_rgb   <= rgb_d;
      end
   end

endmodule

// File: tb/tb_countdown_sprite_draw.sv
// Bench for countdown_sprite_draw: pixel scoreboard plus frame-window sequences.
module tb_countdown_sprite_draw;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       start = 1'b0;
   logic [9:0] DrawX = '0;
   logic [9:0] DrawY = '0;
   logic [9:0] spr [0:23][0:31];
   logic [9:0] pix_rgb;
   logic       pix_valid;
   logic       active;
   logic       done;

   countdown_sprite_draw #(
      .X0(304), .Y0(228), .KEY(10'd391), .HOLD_FRAMES(3)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
      .DrawX(DrawX), .DrawY(DrawY), .sprite(spr),
      .pix_rgb(pix_rgb), .pix_valid(pix_valid), .active(active), .done(done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit         v;
      logic [9:0] rgb;
      string      name;
   } scb_t;

   typedef struct {
      int         x;
      int         y;
      bit         exp_valid;
      logic [9:0] exp_rgb;
      string      name;
   } vec_t;

   scb_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   logic tag_in = 1'b0, tag_d1 = 1'b0, tag_d2 = 1'b0;

   function automatic logic [9:0] spr_color(int r, int c);
      if (r == 4 && c == 3) return 10'd430;
      if ((r + c) % 5 == 0) return 10'd391;
      return 10'((r * 37 + c * 11 + 100) % 1024);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Output lags input by two clocks; mirror that with a tag pipe.
   always @(posedge Clk) begin
      tag_d1 <= tag_in;
      tag_d2 <= tag_d1;
   end

   always @(negedge Clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (tag_d2) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
         end else begin
            scb_t e;
            e = exp_q.pop_front();
            check({e.name, "_valid"}, int'(pix_valid), int'(e.v));
            check({e.name, "_rgb"}, int'(pix_rgb), int'(e.rgb));
         end
      end
   end

   task automatic cycles(input int n);
      tag_in = 1'b0;
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic pix(input int x, input int y, input bit v, input logic [9:0] rgb,
                      input string name);
      scb_t e;
      e.v = v; e.rgb = v ? rgb : 10'd0; e.name = name;
      exp_q.push_back(e);
      DrawX  = 10'(x);
      DrawY  = 10'(y);
      tag_in = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic pix_model(input int x, input int y, input bit act, input string name);
      bit         inb;
      logic [9:0] col;
      inb = (x >= 304) && (x < 336) && (y >= 228) && (y < 252);
      col = inb ? spr_color(y - 228, x - 304) : 10'd0;
      pix(x, y, inb && act && (col != 10'd391), col, name);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      check("start_active", int'(active), 1);
   endtask

   // One frame_clk rising edge; optionally raise start while the tick is live.
   task automatic frame_edge(input bit exp_done, input bit with_start, input string nm);
      frame_clk = 1'b1;
      @(posedge Clk);
      #1;
      check({nm, "_pre_active"}, int'(active), 1);
      if (with_start) start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      check({nm, "_done"}, int'(done), int'(exp_done));
      check({nm, "_active"}, int'(active), int'(!exp_done));
      @(posedge Clk);
      #1;
      check({nm, "_done_next"}, int'(done), 0);
      cycles(2);
      frame_clk = 1'b0;
      cycles(3);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{307, 232, 1'b1, 10'd430, "three_r4c3"};
      vecs[1] = '{304, 228, 1'b0, 10'd0,   "key_origin"};
      vecs[2] = '{303, 240, 1'b0, 10'd0,   "x303"};
      vecs[3] = '{304, 240, 1'b1, 10'd544, "x304"};
      vecs[4] = '{335, 240, 1'b1, 10'd885, "x335"};
      vecs[5] = '{336, 240, 1'b0, 10'd0,   "x336"};
      vecs[6] = '{320, 227, 1'b0, 10'd0,   "y227"};
      vecs[7] = '{320, 228, 1'b1, 10'd276, "y228"};
      vecs[8] = '{320, 251, 1'b1, 10'd103, "y251"};
      vecs[9] = '{320, 252, 1'b0, 10'd0,   "y252"};

      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 32; c++)
            spr[r][c] = spr_color(r, c);

      #12;
      check("rst_pix_rgb", int'(pix_rgb), 0);
      check("rst_pix_valid", int'(pix_valid), 0);
      check("rst_active", int'(active), 0);
      check("rst_done", int'(done), 0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      // Subsampled full-screen sweep with no start: nothing may be drawn.
      for (int y = 0; y < 480; y += 12)
         for (int x = 0; x < 640; x += 5)
            pix_model(x, y, 1'b0, "idle_sweep");
      cycles(3);
      check("idle_active", int'(active), 0);
      check("idle_done_cnt", done_cnt, 0);

      do_start();
      foreach (vecs[i]) pix(vecs[i].x, vecs[i].y, vecs[i].exp_valid, vecs[i].exp_rgb,
                            vecs[i].name);
      for (int y = 226; y < 254; y += 3)
         for (int x = 300; x < 340; x++)
            pix_model(x, y, 1'b1, "box_scan");
      cycles(3);

      // Window of three frames.
      frame_edge(1'b0, 1'b0, "a_f1");
      frame_edge(1'b0, 1'b0, "a_f2");
      frame_edge(1'b1, 1'b0, "a_f3");
      check("a_done_cnt", done_cnt, 1);
      pix_model(307, 232, 1'b0, "after_window");
      cycles(3);

      // Restart after two frames: done only after the fifth edge.
      do_start();
      frame_edge(1'b0, 1'b0, "b_f1");
      frame_edge(1'b0, 1'b0, "b_f2");
      do_start();
      frame_edge(1'b0, 1'b0, "b_f3");
      frame_edge(1'b0, 1'b0, "b_f4");
      frame_edge(1'b1, 1'b0, "b_f5");
      check("b_done_cnt", done_cnt, 2);

      // Start coincident with the final tick suppresses done.
      do_start();
      frame_edge(1'b0, 1'b0, "c_f1");
      frame_edge(1'b0, 1'b0, "c_f2");
      frame_edge(1'b0, 1'b1, "c_f3_start");
      frame_edge(1'b0, 1'b0, "c_f4");
      frame_edge(1'b0, 1'b0, "c_f5");
      frame_edge(1'b1, 1'b0, "c_f6");
      check("c_done_cnt", done_cnt, 3);

      // Asynchronous reset during an in-box scan.
      do_start();
      DrawX = 10'd307;
      DrawY = 10'd232;
      cycles(3);
      check("d_pre_valid", int'(pix_valid), 1);
      check("d_pre_rgb", int'(pix_rgb), 430);
      Reset = 1'b1;
      #2;
      check("d_rst_active", int'(active), 0);
      check("d_rst_valid", int'(pix_valid), 0);
      check("d_rst_rgb", int'(pix_rgb), 0);
      cycles(2);
      Reset = 1'b0;
      cycles(2);
      check("d_no_done", done_cnt, 3);
      do_start();
      pix_model(307, 232, 1'b1, "d_after_restart");
      cycles(3);
      frame_edge(1'b0, 1'b0, "d_f1");
      frame_edge(1'b0, 1'b0, "d_f2");
      frame_edge(1'b1, 1'b0, "d_f3");
      check("d_done_cnt", done_cnt, 4);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
